// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: holds one instruction from execute, issues at most one
// load/store on the valid/ready data bus, and hands the aligned/extended result to writeback.
module mem_stage_lsu #(
    parameter int WIDTH    = 64,
    parameter int GPR_SIZE = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                regE_to_regM_valid,
    output logic                regM_allow_in,
    input  logic                in_is_load,
    input  logic                in_is_store,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [WIDTH-1:0]    in_addr,
    input  logic [WIDTH-1:0]    in_wdata,
    input  logic [WIDTH-1:0]    in_alu_result,
    input  logic [GPR_SIZE-1:0] in_rd,
    input  logic                regW_allow_in,
    output logic                regM_to_regW_valid,
    output logic [GPR_SIZE-1:0] out_rd,
    output logic [WIDTH-1:0]    out_wb_data,
    output logic                out_misalign,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [WIDTH-1:0]    mem_req_addr,
    output logic [WIDTH-1:0]    mem_req_wdata,
    output logic [7:0]          mem_req_wstrb,
    input  logic                mem_resp_valid,
    input  logic [WIDTH-1:0]    mem_resp_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                valid_q;
    logic                ready_go, accept, is_mem_in, misalign_in, capture;
    logic [1:0]          size_q;
    logic                unsigned_q, load_q, we_q, mis_q;
    logic [2:0]          off_q;
    logic [WIDTH-1:0]    addr_q, wdata_q, wb_q;
    logic [7:0]          wstrb_q, mask_in;
    logic [GPR_SIZE-1:0] rd_q;
    logic [WIDTH-1:0]    wdata_rep, shifted, load_ext;

    assign is_mem_in = in_is_load | in_is_store;
    assign accept    = regE_to_regM_valid & regM_allow_in;
    assign capture   = mem_resp_valid &
                       (((state_q == S_REQ) && mem_req_ready) || (state_q == S_WAIT));

    always_comb begin
        misalign_in = 1'b0;
        mask_in     = 8'h01;
        wdata_rep   = in_wdata;
        case (in_size)
            2'd0: begin
                mask_in   = 8'h01;
                wdata_rep = {(WIDTH/8){in_wdata[7:0]}};
            end
            2'd1: begin
                misalign_in = in_addr[0];
                mask_in     = 8'h03;
                wdata_rep   = {(WIDTH/16){in_wdata[15:0]}};
            end
            2'd2: begin
                misalign_in = |in_addr[1:0];
                mask_in     = 8'h0F;
                wdata_rep   = {(WIDTH/32){in_wdata[31:0]}};
            end
            default: begin
                misalign_in = |in_addr[2:0];
                mask_in     = 8'hFF;
                wdata_rep   = in_wdata;
            end
        endcase
    end

    // Response word is shifted so the addressed byte lands in lane 0, then extended.
    always_comb begin
        shifted  = mem_resp_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0: load_ext = {{(WIDTH-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = {{(WIDTH-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
            2'd2: load_ext = {{(WIDTH-32){~unsigned_q & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (regM_allow_in)
                    state_d = (accept && is_mem_in && !misalign_in) ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                if (mem_req_ready) state_d = mem_resp_valid ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_go           = (state_q == S_IDLE) || (state_q == S_DONE);
        regM_allow_in      = !valid_q || (ready_go && regW_allow_in);
        regM_to_regW_valid = valid_q && ready_go;
        mem_req_valid      = (state_q == S_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            load_q     <= 1'b0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            off_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 8'h00;
            rd_q       <= '0;
            wb_q       <= '0;
        end else begin
            if (regM_allow_in) valid_q <= regE_to_regM_valid;
            if (accept) begin
                size_q     <= in_size;
                unsigned_q <= in_unsigned;
                load_q     <= in_is_load;
                we_q       <= in_is_store;
                mis_q      <= is_mem_in & misalign_in;
                off_q      <= in_addr[2:0];
                addr_q     <= {in_addr[WIDTH-1:3], 3'b000};
                wdata_q    <= wdata_rep;
                wstrb_q    <= in_is_store ? 8'(mask_in << in_addr[2:0]) : 8'h00;
                rd_q       <= in_rd;
                wb_q       <= is_mem_in ? '0 : in_alu_result;
            end else if (capture) begin
                wb_q <= load_q ? load_ext : '0;
            end
        end
    end

    assign out_rd        = rd_q;
    assign out_wb_data   = wb_q;
    assign out_misalign  = mis_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table of single operations plus hand-written
// sequences for back-to-back issue, bus/writeback backpressure and reset during a wait.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regE_to_regM_valid = 1'b0;
    logic        regM_allow_in;
    logic        in_is_load = 1'b0, in_is_store = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic        in_unsigned = 1'b0;
    logic [63:0] in_addr = '0, in_wdata = '0, in_alu_result = '0;
    logic [4:0]  in_rd = '0;
    logic        regW_allow_in = 1'b1;
    logic        regM_to_regW_valid;
    logic [4:0]  out_rd;
    logic [63:0] out_wb_data;
    logic        out_misalign;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    mem_stage_lsu #(.WIDTH(64), .GPR_SIZE(5)) dut (
        .clk(clk), .rst(rst),
        .regE_to_regM_valid(regE_to_regM_valid), .regM_allow_in(regM_allow_in),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_result(in_alu_result), .in_rd(in_rd),
        .regW_allow_in(regW_allow_in), .regM_to_regW_valid(regM_to_regW_valid),
        .out_rd(out_rd), .out_wb_data(out_wb_data), .out_misalign(out_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req_valid && mem_req_ready) hs_cnt++;

    typedef struct {
        logic        ld, st;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr, wdata, alu, rdata;
        logic [4:0]  rd;
        logic [63:0] exp_wb;
        logic        exp_mis;
        logic [63:0] exp_raddr, exp_rwdata;
        logic [7:0]  exp_strb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        regE_to_regM_valid = 1'b1;
        in_is_load    = v.ld;
        in_is_store   = v.st;
        in_size       = v.sz;
        in_unsigned   = v.uns;
        in_addr       = v.addr;
        in_wdata      = v.wdata;
        in_alu_result = v.alu;
        in_rd         = v.rd;
    endtask

    function automatic vec_t mk(logic ld, logic st, logic [1:0] sz, logic uns,
                                logic [63:0] addr, logic [63:0] wdata, logic [63:0] alu,
                                logic [63:0] rdata, logic [4:0] rd, logic [63:0] exp_wb,
                                logic exp_mis, logic [63:0] exp_raddr,
                                logic [63:0] exp_rwdata, logic [7:0] exp_strb);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.alu = alu; v.rdata = rdata; v.rd = rd; v.exp_wb = exp_wb; v.exp_mis = exp_mis;
        v.exp_raddr = exp_raddr; v.exp_rwdata = exp_rwdata; v.exp_strb = exp_strb;
        return v;
    endfunction

    // One isolated operation: accept, optional bus request/response, then check the result.
    task automatic run_op(input vec_t v, input int idx);
        drive(v);
        regW_allow_in = 1'b1;
        #1;
        chk($sformatf("v%0d_allow_in", idx), 64'(regM_allow_in), 64'd1);
        cyc();
        regE_to_regM_valid = 1'b0;
        if ((v.ld || v.st) && !v.exp_mis) begin
            chk($sformatf("v%0d_req_valid", idx), 64'(mem_req_valid), 64'd1);
            chk($sformatf("v%0d_w_valid_req", idx), 64'(regM_to_regW_valid), 64'd0);
            chk($sformatf("v%0d_req_addr", idx), mem_req_addr, v.exp_raddr);
            chk($sformatf("v%0d_req_we", idx), 64'(mem_req_we), 64'(v.st));
            if (v.st) begin
                chk($sformatf("v%0d_req_wdata", idx), mem_req_wdata, v.exp_rwdata);
                chk($sformatf("v%0d_req_wstrb", idx), 64'(mem_req_wstrb), 64'(v.exp_strb));
            end
            mem_req_ready = 1'b1;
            cyc();
            mem_req_ready = 1'b0;
            chk($sformatf("v%0d_wait_w_valid", idx), 64'(regM_to_regW_valid), 64'd0);
            chk($sformatf("v%0d_wait_req", idx), 64'(mem_req_valid), 64'd0);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = v.rdata;
            cyc();
            mem_resp_valid = 1'b0;
        end else begin
            chk($sformatf("v%0d_no_req", idx), 64'(mem_req_valid), 64'd0);
        end
        chk($sformatf("v%0d_w_valid", idx), 64'(regM_to_regW_valid), 64'd1);
        chk($sformatf("v%0d_wb_data", idx), out_wb_data, v.exp_wb);
        chk($sformatf("v%0d_rd", idx), 64'(out_rd), 64'(v.rd));
        chk($sformatf("v%0d_misalign", idx), 64'(out_misalign), 64'(v.exp_mis));
        cyc();
    endtask

    initial begin
        vecs.push_back(mk(0,0,0,0, 64'h0, 0, 64'h1234, 0, 7, 64'h1234, 0, 0, 0, 0));
        vecs.push_back(mk(1,0,0,0, 64'h1003, 0, 0, 64'h00000000_80000000, 1,
                          64'hFFFFFFFF_FFFFFF80, 0, 64'h1000, 0, 0));
        vecs.push_back(mk(1,0,0,1, 64'h1003, 0, 0, 64'h00000000_80000000, 2,
                          64'h80, 0, 64'h1000, 0, 0));
        vecs.push_back(mk(0,1,1,0, 64'h2006, 64'hBEEF, 0, 0, 3, 0, 0, 64'h2000,
                          64'hBEEFBEEF_BEEFBEEF, 8'hC0));
        vecs.push_back(mk(1,0,2,0, 64'h3001, 0, 0, 0, 4, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,0,1,0, 64'h12, 0, 0, 64'h11223344_85667788, 5,
                          64'hFFFFFFFF_FFFF8566, 0, 64'h10, 0, 0));
        vecs.push_back(mk(1,0,2,1, 64'h104, 0, 0, 64'h89ABCDEF_01234567, 6,
                          64'h00000000_89ABCDEF, 0, 64'h100, 0, 0));
        vecs.push_back(mk(1,0,2,0, 64'h104, 0, 0, 64'h89ABCDEF_01234567, 8,
                          64'hFFFFFFFF_89ABCDEF, 0, 64'h100, 0, 0));
        vecs.push_back(mk(1,0,3,1, 64'h200, 0, 0, 64'hFEDCBA98_76543210, 9,
                          64'hFEDCBA98_76543210, 0, 64'h200, 0, 0));
        vecs.push_back(mk(0,1,0,0, 64'h405, 64'h123456A5, 0, 0, 10, 0, 0, 64'h400,
                          64'hA5A5A5A5_A5A5A5A5, 8'h20));
        vecs.push_back(mk(0,1,2,0, 64'h44, 64'hFFFFFFFF_CAFEF00D, 0, 0, 11, 0, 0, 64'h40,
                          64'hCAFEF00D_CAFEF00D, 8'hF0));
        vecs.push_back(mk(0,1,3,0, 64'h48, 64'h01020304_05060708, 0, 0, 12, 0, 0, 64'h48,
                          64'h01020304_05060708, 8'hFF));
        vecs.push_back(mk(0,1,3,0, 64'h4C, 64'h55, 0, 0, 13, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,0,1,0, 64'h7, 0, 0, 0, 14, 0, 1, 0, 0, 0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_valid", 64'(regM_to_regW_valid), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_wb_data", out_wb_data, 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_misalign", 64'(out_misalign), 64'd0);
        rst = 1'b0;
        cyc();

        foreach (vecs[i]) run_op(vecs[i], i);

        // back-to-back non-memory issue, one per cycle
        for (int i = 0; i < 3; i++) begin
            regE_to_regM_valid = 1'b1;
            in_is_load = 1'b0; in_is_store = 1'b0;
            in_alu_result = 64'h1000 + 64'(i); in_rd = 5'(20 + i);
            #1;
            chk($sformatf("b2b%0d_allow_in", i), 64'(regM_allow_in), 64'd1);
            cyc();
            chk($sformatf("b2b%0d_w_valid", i), 64'(regM_to_regW_valid), 64'd1);
            chk($sformatf("b2b%0d_wb", i), out_wb_data, 64'h1000 + 64'(i));
            chk($sformatf("b2b%0d_rd", i), 64'(out_rd), 64'(20 + i));
        end
        regE_to_regM_valid = 1'b0;
        cyc();
        chk("b2b_drain", 64'(regM_to_regW_valid), 64'd0);

        // bus and writeback backpressure, then a load accepted directly from DONE
        drive(mk(0,1,1,0, 64'h2006, 64'hBEEF, 0, 0, 15, 0, 0, 0, 0, 0));
        cyc();
        drive(mk(1,0,0,1, 64'h1003, 0, 0, 0, 16, 0, 0, 0, 0, 0));
        begin
            int hs0;
            hs0 = hs_cnt;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("bp%0d_req_valid", i), 64'(mem_req_valid), 64'd1);
                chk($sformatf("bp%0d_addr", i), mem_req_addr, 64'h2000);
                chk($sformatf("bp%0d_wdata", i), mem_req_wdata, 64'hBEEFBEEF_BEEFBEEF);
                chk($sformatf("bp%0d_wstrb", i), 64'(mem_req_wstrb), 64'hC0);
                chk($sformatf("bp%0d_we", i), 64'(mem_req_we), 64'd1);
                chk($sformatf("bp%0d_allow_in", i), 64'(regM_allow_in), 64'd0);
                cyc();
            end
            mem_req_ready = 1'b1;
            mem_resp_valid = 1'b1;
            regW_allow_in = 1'b0;
            cyc();
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("wbs%0d_w_valid", i), 64'(regM_to_regW_valid), 64'd1);
                chk($sformatf("wbs%0d_rd", i), 64'(out_rd), 64'd15);
                chk($sformatf("wbs%0d_wb", i), out_wb_data, 64'd0);
                chk($sformatf("wbs%0d_allow_in", i), 64'(regM_allow_in), 64'd0);
                chk($sformatf("wbs%0d_req_valid", i), 64'(mem_req_valid), 64'd0);
                cyc();
            end
            chk("bp_one_transfer", 64'(hs_cnt - hs0), 64'd1);
        end
        regW_allow_in = 1'b1;
        #1;
        chk("done_allow_in", 64'(regM_allow_in), 64'd1);
        cyc();
        regE_to_regM_valid = 1'b0;
        chk("b2b_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("b2b_mem_addr", mem_req_addr, 64'h1000);
        chk("b2b_mem_we", 64'(mem_req_we), 64'd0);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h00000000_80000000;
        cyc();
        mem_resp_valid = 1'b0;
        chk("b2b_mem_w_valid", 64'(regM_to_regW_valid), 64'd1);
        chk("b2b_mem_wb", out_wb_data, 64'h80);
        chk("b2b_mem_rd", 64'(out_rd), 64'd16);
        cyc();

        // asynchronous reset while waiting for a response; late response ignored
        drive(mk(1,0,0,0, 64'h1003, 0, 0, 0, 9, 0, 0, 0, 0, 0));
        cyc();
        regE_to_regM_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_w_valid", 64'(regM_to_regW_valid), 64'd0);
        chk("arst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("arst_rd", 64'(out_rd), 64'd0);
        chk("arst_allow_in", 64'(regM_allow_in), 64'd1);
        #1;
        rst = 1'b0;
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hFFFFFFFF_FFFFFFFF;
        cyc();
        mem_resp_valid = 1'b0;
        chk("late_w_valid", 64'(regM_to_regW_valid), 64'd0);
        chk("late_wb", out_wb_data, 64'd0);
        chk("late_req_valid", 64'(mem_req_valid), 64'd0);
        cyc();
        chk("late_idle_w_valid", 64'(regM_to_regW_valid), 64'd0);
        chk("late_idle_allow", 64'(regM_allow_in), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
